serial_input_driver: RTL and testbench
======================================

// Module: serial_input_driver
// PURPOSE
//   Upstream feeder for the network's input shift register. Accepts one parallel input frame
//   (numInputs words of dataWidth bits) via a valid/ready handshake. Serialises the frame MSB-first
//   on serialData with a generated serialClock, then pulses pushBuffer so the receiver commits
//   the frame to its dataOut.
//   Runs entirely on CLOCK_50; serialClock is a divided, registered output, not a second clock domain.
// PARAMETERS
//   numInputs   8   words per frame
//   dataWidth   4   bits per word; totalBits = numInputs*dataWidth (default 32)
//   halfPeriod  2   CLOCK_50 cycles per serialClock half-period (>=1)
//   pushWidth   1   CLOCK_50 cycles pushBuffer is held high (>=1)
// PORTS
//   CLOCK_50     in   1          system clock; all logic on rising edge
//   reset        in   1          synchronous, active-high
//   inData       in   totalBits  parallel frame; word 0 in MSBs
//   inValid      in   1          inData valid
//   inReady      out  1          block can accept a frame (high only in IDLE)
//   serialClock  out  1          generated serial clock; receiver samples serialData on its rising edge
//   serialData   out  1          serial bit stream, MSB of frame first
//   pushBuffer   out  1          frame-complete strobe to receiver
//   busy         out  1          frame in flight (SHIFT or PUSH)
// BEHAVIOUR
//   - All outputs registered. Reset values: inReady=1 (after the reset cycle), all other outputs 0.
//     Internal state returns to IDLE.
//   - FSM states IDLE -> SHIFT -> PUSH -> IDLE.
//   - IDLE:
//     - inReady=1, busy=0, serialClock=0, serialData=0, pushBuffer=0.
//     - On an edge with inValid&inReady: latch inData into a shift reg, bitCnt=totalBits-1,
//       phaseCnt=0, go SHIFT.
//   - SHIFT:
//     - Each bit occupies 2*halfPeriod cycles: LOW phase (halfPeriod cycles, serialClock=0),
//       then HIGH phase (halfPeriod cycles, serialClock=1).
//     - serialData takes the next bit in the first LOW-phase cycle and is held through the HIGH phase.
//       Data is therefore stable >= halfPeriod cycles before and during each rising edge.
//     - The first bit appears the cycle after acceptance.
//     - At the end of the HIGH phase: if bitCnt==0, go PUSH with serialClock=0; else decrement
//       bitCnt and start the next LOW phase.
//   - PUSH:
//     - pushBuffer=1 for exactly pushWidth cycles; serialClock=0; serialData holds the last bit.
//     - Then IDLE with pushBuffer=0 and inReady=1.
//   - Latency: accept edge to first serialData cycle = 1. Busy span = totalBits*2*halfPeriod + pushWidth
//     cycles (129 at defaults). Minimum frame-to-frame accept spacing = busy span + 1.
//   - inValid/inData ignored while busy. A frame is never truncated or restarted by new input.
//     Back-to-back frames: inValid held high is accepted on the first IDLE cycle.
//   - Exactly totalBits rising serialClock edges and one pushBuffer pulse per frame.
//     serialClock is never high in IDLE or PUSH.
//   - Reset mid-SHIFT or mid-PUSH: the next cycle is IDLE with outputs at reset values and no
//     pushBuffer pulse. Partial frame discarded. Reset dominates a simultaneous inValid.
//   - Counters: bitCnt width clog2(totalBits); phaseCnt width clog2(halfPeriod)+1. No wrap occurs
//     within a frame.
// TESTING
//   1. Reset then idle 5 cycles -> inReady=1, busy=0, serialClock=serialData=pushBuffer=0 throughout.
//   2. inData=32'hA5C3_0F96, one-cycle inValid -> bits sampled on 32 serialClock rises equal
//      1010_0101_1100_0011_0000_1111_1001_0110; pushBuffer high 1 cycle at cycle 129; inReady back at cycle 130.
//   3. Case 2 connected to inputShiftRegister(8,4) on CLOCK_50 -> receiver dataOut==32'hA5C3_0F96
//      after pushBuffer.
//   4. inValid held high with 32'hFFFF_0000 then 32'h0000_FFFF -> second frame accepted on the first IDLE
//      cycle; a toggled inData during frame 1 does not disturb it.
//   5. reset asserted at bit 10 of a frame -> next cycle all outputs 0, no pushBuffer; a new frame
//      afterwards transmits correctly.
//   6. halfPeriod=1, pushWidth=3 -> serialClock period 2 cycles, pushBuffer high exactly 3 cycles, busy span 67.

Source files
------------

// File: rtl/serial_input_driver.sv
// Purpose: serialise one parallel frame MSB-first with a generated serialClock, then strobe pushBuffer.
// Latency: first bit is driven the cycle after accept; busy lasts totalBits*2*halfPeriod + pushWidth cycles.
// Backpressure: inReady is high only in IDLE; inValid/inData are ignored while a frame is in flight.
module serial_input_driver #(
  parameter int numInputs  = 8,
  parameter int dataWidth  = 4,
  parameter int halfPeriod = 2,
  parameter int pushWidth  = 1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [numInputs*dataWidth-1:0] inData,
  input  logic                           inValid,
  output logic                           inReady,
  output logic                           serialClock,
  output logic                           serialData,
  output logic                           pushBuffer,
  output logic                           busy
);

  localparam int TOTAL_BITS = numInputs * dataWidth;
  localparam int BIT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int PHASE_W    = $clog2(halfPeriod) + 1;
  localparam int PUSH_W     = $clog2(pushWidth) + 1;

  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(TOTAL_BITS - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(halfPeriod);
  localparam logic [PHASE_W-1:0] PHASE_END  = PHASE_W'(2 * halfPeriod - 1);
  localparam logic [PUSH_W-1:0]  PUSH_END   = PUSH_W'(pushWidth - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   shift_q, shift_d;        // bits still to be sent, next one in MSB
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;    // bits remaining after the current one
  logic [PHASE_W-1:0]      phase_cnt_q, phase_cnt_d; // position within the current bit: 0..2*halfPeriod-1
  logic [PUSH_W-1:0]       push_cnt_q, push_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    serial_clock_q, serial_clock_d;
  logic                    serial_data_q, serial_data_d;
  logic                    push_buffer_q, push_buffer_d;
  logic                    busy_q, busy_d;
  logic [PHASE_W-1:0]      phase_inc;

  // Next-state and registered-output computation; every output is a flop so the
  // serial clock and data leave the block glitch-free and aligned.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    phase_cnt_d    = phase_cnt_q;
    push_cnt_d     = push_cnt_q;
    in_ready_d     = in_ready_q;
    serial_clock_d = serial_clock_q;
    serial_data_d  = serial_data_q;
    push_buffer_d  = push_buffer_q;
    busy_d         = busy_q;
    phase_inc      = phase_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          // First bit goes straight to the output so it is present in the first LOW cycle.
          serial_data_d  = inData[TOTAL_BITS-1];
          shift_d        = inData << 1;
          bit_cnt_d      = BIT_LAST;
          phase_cnt_d    = '0;
          serial_clock_d = 1'b0;
          in_ready_d     = 1'b0;
          busy_d         = 1'b1;
          state_d        = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (phase_cnt_q == PHASE_END) begin
          serial_clock_d = 1'b0;
          if (bit_cnt_q == '0) begin
            // Last bit's HIGH phase is done; serialData keeps the last bit through PUSH.
            push_cnt_d    = '0;
            push_buffer_d = 1'b1;
            state_d       = ST_PUSH;
          end else begin
            bit_cnt_d     = bit_cnt_q - 1'b1;
            phase_cnt_d   = '0;
            serial_data_d = shift_q[TOTAL_BITS-1];
            shift_d       = shift_q << 1;
          end
        end else begin
          phase_cnt_d    = phase_inc;
          serial_clock_d = (phase_inc >= PHASE_HIGH);
        end
      end

      ST_PUSH: begin
        if (push_cnt_q == PUSH_END) begin
          push_buffer_d = 1'b0;
          serial_data_d = 1'b0;
          busy_d        = 1'b0;
          in_ready_d    = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          push_cnt_d = push_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        serial_clock_d = 1'b0;
        serial_data_d  = 1'b0;
        push_buffer_d  = 1'b0;
        busy_d         = 1'b0;
        in_ready_d     = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame without a push strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      phase_cnt_q    <= '0;
      push_cnt_q     <= '0;
      in_ready_q     <= 1'b1;
      serial_clock_q <= 1'b0;
      serial_data_q  <= 1'b0;
      push_buffer_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      phase_cnt_q    <= phase_cnt_d;
      push_cnt_q     <= push_cnt_d;
      in_ready_q     <= in_ready_d;
      serial_clock_q <= serial_clock_d;
      serial_data_q  <= serial_data_d;
      push_buffer_q  <= push_buffer_d;
      busy_q         <= busy_d;
    end
  end

  assign inReady     = in_ready_q;
  assign serialClock = serial_clock_q;
  assign serialData  = serial_data_q;
  assign pushBuffer  = push_buffer_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_input_driver.sv
// Purpose: check serial_input_driver against a per-cycle arithmetic model and a receiver model.
// Latency: model predicts every output of every cycle from the cycle index since accept.
// Backpressure: bench drives inValid freely; the model decides acceptance from its own idle state.
module tb_serial_input_driver;

  localparam int TB    = 32;
  localparam int HP    = 2;
  localparam int PW    = 1;
  localparam int SPAN  = TB * 2 * HP + PW;   // 129
  localparam int HP2   = 1;
  localparam int PW2   = 3;
  localparam int SPAN2 = TB * 2 * HP2 + PW2; // 67

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [TB-1:0] inData, inData2;
  logic          inValid, inValid2;
  logic          inReady, serialClock, serialData, pushBuffer, busy;
  logic          inReady2, serialClock2, serialData2, pushBuffer2, busy2;
  logic [4:0]    outs, outs2;

  assign outs  = {inReady, busy, serialClock, serialData, pushBuffer};
  assign outs2 = {inReady2, busy2, serialClock2, serialData2, pushBuffer2};

  always #5 CLOCK_50 = ~CLOCK_50;

  serial_input_driver #(.numInputs(8), .dataWidth(4), .halfPeriod(HP), .pushWidth(PW)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .inData(inData), .inValid(inValid),
    .inReady(inReady), .serialClock(serialClock), .serialData(serialData),
    .pushBuffer(pushBuffer), .busy(busy)
  );

  serial_input_driver #(.numInputs(8), .dataWidth(4), .halfPeriod(HP2), .pushWidth(PW2)) u_dut2 (
    .CLOCK_50(CLOCK_50), .reset(reset), .inData(inData2), .inValid(inValid2),
    .inReady(inReady2), .serialClock(serialClock2), .serialData(serialData2),
    .pushBuffer(pushBuffer2), .busy(busy2)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            m_k   = 0;          // cycles since accept (0 = idle)
  logic [TB-1:0] m_frame = '0;
  logic [TB-1:0] exp_q[$];
  logic [TB-1:0] rx = '0;
  logic [TB-1:0] last_rx = '0;
  int            rises = 0;
  logic          prev_sclk = 1'b0;
  logic          prev_push = 1'b0;

  typedef struct {
    logic [TB-1:0] din;
    logic [TB-1:0] exp_rx;
    int            exp_push_k;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected {inReady, busy, serialClock, serialData, pushBuffer} for cycle k after accept.
  function automatic logic [4:0] model_out(input int hp, input int pw, input int k,
                                           input logic [TB-1:0] frame);
    int shift_len;
    int i;
    shift_len = TB * 2 * hp;
    if (k == 0) return 5'b10000;
    if (k <= shift_len) begin
      i = (k - 1) / (2 * hp);
      return {1'b0, 1'b1, ((k - 1) % (2 * hp)) >= hp, frame[TB-1-i], 1'b0};
    end
    if (k <= shift_len + pw) return {1'b0, 1'b1, 1'b0, frame[0], 1'b1};
    return 5'b10000;
  endfunction

  // One clock of the main instance: advance the model, then check outputs and the receiver.
  task automatic tick();
    @(posedge CLOCK_50);
    if (reset) begin
      m_k = 0;
      exp_q.delete();
      rises = 0;
    end else if (m_k == 0) begin
      if (inValid) begin
        m_k     = 1;
        m_frame = inData;
        exp_q.push_back(inData);
      end
    end else if (m_k == SPAN) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    #1;
    cyc++;
    chk("outputs", {27'd0, outs}, {27'd0, model_out(HP, PW, m_k, m_frame)});
    if (serialClock && !prev_sclk) begin
      rx = {rx[TB-2:0], serialData};
      rises++;
    end
    if (pushBuffer && !prev_push) begin
      chk("rise_count", rises, TB);
      rises   = 0;
      last_rx = rx;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_frame: push with no frame outstanding (cycle %0d)", cyc);
      end else begin
        chk("rx_frame", rx, exp_q.pop_front());
      end
    end
    prev_sclk = serialClock;
    prev_push = pushBuffer;
  endtask

  // Offer a frame for one edge, wait (bounded) for its push, then check the IDLE return.
  task automatic run_frame(input logic [TB-1:0] din, input logic [TB-1:0] exp_rx, input int exp_push_k);
    int n;
    inValid = 1'b1;
    inData  = din;
    tick();
    inValid = 1'b0;
    n = 1;
    while (!pushBuffer && n < 400) begin
      tick();
      n++;
    end
    chk("push_cycle", n, exp_push_k);
    chk("frame_data", last_rx, exp_rx);
    tick();
    chk("ready_after_push", {inReady, pushBuffer}, 2'b10);
  endtask

  initial begin
    int p2;
    int b2;
    int r2;
    logic [TB-1:0] rx2;
    logic prev2;

    vecs[0] = '{32'hA5C3_0F96, 32'hA5C3_0F96, SPAN};
    vecs[1] = '{32'hFFFF_0000, 32'hFFFF_0000, SPAN};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_FFFF, SPAN};
    vecs[3] = '{32'h8000_0001, 32'h8000_0001, SPAN};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, SPAN};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, SPAN};

    reset = 1'b1; inValid = 1'b0; inData = '0; inValid2 = 1'b0; inData2 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset: ready, everything else low.
    repeat (5) begin
      tick();
      chk("idle_state", {27'd0, outs}, 32'h10);
    end

    // Single frames from the table.
    for (int v = 0; v < 6; v++) run_frame(vecs[v].din, vecs[v].exp_rx, vecs[v].exp_push_k);

    // inValid held high: second frame accepted on the first IDLE cycle, data toggling ignored.
    inValid = 1'b1;
    inData  = 32'hFFFF_0000;
    tick();
    repeat (SPAN) begin
      inData = $urandom;
      tick();
    end
    chk("b2b_idle_ready", inReady, 1'b1);
    inData = 32'h0000_FFFF;
    tick();
    chk("b2b_accepted", {inReady, busy}, 2'b01);
    inValid = 1'b0;
    repeat (SPAN + 1) tick();
    chk("b2b_frame2", last_rx, 32'h0000_FFFF);

    // Reset at the first cycle of bit 10, with inValid also high.
    inValid = 1'b1;
    inData  = 32'h1234_5678;
    tick();
    inValid = 1'b0;
    repeat (40) tick();
    reset   = 1'b1;
    inValid = 1'b1;
    tick();
    chk("reset_midframe", {27'd0, outs}, 32'h10);
    reset   = 1'b0;
    inValid = 1'b0;
    repeat (SPAN) tick();
    run_frame(32'hDEAD_BEEF, 32'hDEAD_BEEF, SPAN);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      inValid = ($urandom_range(0, 3) == 0);
      inData  = $urandom;
      reset   = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset   = 1'b0;
    inValid = 1'b0;
    repeat (SPAN + 2) tick();
    chk("queue_drained", exp_q.size(), 0);

    // halfPeriod=1, pushWidth=3 instance.
    p2 = 0; b2 = 0; r2 = 0; rx2 = '0; prev2 = 1'b0;
    inData2  = 32'hA5C3_0F96;
    inValid2 = 1'b1;
    @(posedge CLOCK_50);
    #1;
    cyc++;
    inValid2 = 1'b0;
    for (int k = 1; k <= SPAN2 + 1; k++) begin
      chk("hp1_outputs", {27'd0, outs2}, {27'd0, model_out(HP2, PW2, (k <= SPAN2) ? k : 0, 32'hA5C3_0F96)});
      p2 += int'(pushBuffer2);
      b2 += int'(busy2);
      if (serialClock2 && !prev2) begin
        rx2 = {rx2[TB-2:0], serialData2};
        r2++;
      end
      prev2 = serialClock2;
      if (k <= SPAN2) begin
        @(posedge CLOCK_50);
        #1;
        cyc++;
      end
    end
    chk("hp1_push_cycles", p2, PW2);
    chk("hp1_busy_span", b2, SPAN2);
    chk("hp1_rises", r2, TB);
    chk("hp1_frame", rx2, 32'hA5C3_0F96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
